// File: rtl/apb3_cmd_master_if.sv
// Bundles the command/response handshake and the APB3 bus of apb3_cmd_master.
// The master modport is the initiator's view; slave is the requester plus APB target.
interface apb3_cmd_master_if #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_WDATA_WIDTH = 32,
  parameter int APB_RDATA_WIDTH = 32
);
  localparam int STRB_W = APB_WDATA_WIDTH / 8;

  // Command request port
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [APB_ADDR_WIDTH-1:0]  cmd_addr;
  logic [APB_WDATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_W-1:0]          cmd_strb;
  logic [2:0]                 cmd_prot;

  // Response port
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [APB_RDATA_WIDTH-1:0] rsp_rdata;
  logic                       rsp_slverr;
  logic                       rsp_timeout;

  // APB3 bus
  logic [APB_ADDR_WIDTH-1:0]  PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [APB_WDATA_WIDTH-1:0] PWDATA;
  logic [APB_RDATA_WIDTH-1:0] PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;
  logic [2:0]                 PPROT;
  logic [STRB_W-1:0]          PSTRB;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb3_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer, and its
// result (read data, slave error, or timeout) comes back on a valid/ready response.
module apb3_cmd_master #(
  parameter int APB_ADDR_WIDTH  = 32,
  parameter int APB_WDATA_WIDTH = 32,
  parameter int APB_RDATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  apb3_cmd_master_if.master  bus
);

  localparam int STRB_W = APB_WDATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                     state_q,       state_d;
  logic [APB_ADDR_WIDTH-1:0]  paddr_q,       paddr_d;
  logic                       pwrite_q,      pwrite_d;
  logic [APB_WDATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic [STRB_W-1:0]          pstrb_q,       pstrb_d;
  logic [2:0]                 pprot_q,       pprot_d;
  logic                       psel_q,        psel_d;
  logic                       penable_q,     penable_d;
  logic                       idle_rdy_q,    idle_rdy_d;
  logic                       rsp_valid_q,   rsp_valid_d;
  logic [APB_RDATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                       rsp_slverr_q,  rsp_slverr_d;
  logic                       rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]           wait_cnt_q,    wait_cnt_d;

  logic cmd_ready;
  logic accept;

  // idle_rdy_q keeps cmd_ready low through reset and for the first cycle after
  // release; in RESP the next command may be taken in the same cycle the
  // response is consumed, which is what gives SETUP-ACCESS-RESP throughput.
  assign cmd_ready = idle_rdy_q | (rsp_valid_q & bus.rsp_ready);
  assign accept    = bus.cmd_valid & cmd_ready;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case
    // below leaves a variable unassigned and no latch is inferred.
    state_d       = state_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    idle_rdy_d    = idle_rdy_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!accept) idle_rdy_d = 1'b1;
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_slverr_d  = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TIMEOUT_CYCLES != 0) begin
          // The counter already holds the number of waited edges, so the abort
          // lands on the edge after the last allowed wait and PREADY there still wins.
          if (wait_cnt_q == CNT_LIMIT) begin
            rsp_rdata_d   = '0;
            rsp_slverr_d  = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            state_d       = RESP;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!bus.cmd_valid) begin
            idle_rdy_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // A command can be taken from IDLE or, back-to-back, from RESP.
    if (accept) begin
      paddr_d    = bus.cmd_addr;
      pwrite_d   = bus.cmd_write;
      pwdata_d   = bus.cmd_wdata;
      pstrb_d    = bus.cmd_write ? bus.cmd_strb : '0;
      pprot_d    = bus.cmd_prot;
      psel_d     = 1'b1;
      penable_d  = 1'b0;
      idle_rdy_d = 1'b0;
      wait_cnt_d = '0;
      state_d    = SETUP;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      idle_rdy_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      idle_rdy_q    <= idle_rdy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign bus.PADDR   = paddr_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PSTRB   = pstrb_q;
  assign bus.PPROT   = pprot_q;

endmodule

// File: doc/apb3_cmd_master.md
# apb3_cmd_master

APB3 initiator that turns single-transfer commands from a valid/ready request port into APB3 read or write transfers, and returns each result on a valid/ready response port. It is the bus-master counterpart to the APB3 slave register blocks in the design, for example the ALU's a/b/op/result/ctrl register file at offsets 0x000–0x010. It lets an RTL sequencer or firmware model program those blocks without a testbench VIP. It supports one outstanding transfer, slave wait states, PSLVERR capture and a configurable no-PREADY timeout.

## Interface
- APB_ADDR_WIDTH, 32, PADDR / cmd_addr width
- APB_WDATA_WIDTH, 32, PWDATA / cmd_wdata width; PSTRB width = APB_WDATA_WIDTH/8
- APB_RDATA_WIDTH, 32, PRDATA / rsp_rdata width
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without PREADY before the transfer is aborted; 0 disables the timeout
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  APB_ADDR_WIDTH  transfer address
- cmd_wdata  in  APB_WDATA_WIDTH  write data
- cmd_strb  in  APB_WDATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  APB_RDATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_slverr  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout  out  1  transfer aborted by the timeout
- PADDR  out  APB_ADDR_WIDTH  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  APB_WDATA_WIDTH  APB write data
- PRDATA  in  APB_RDATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error
- PPROT  out  3  APB protection
- PSTRB  out  APB_WDATA_WIDTH/8  APB strobes

## Operation
- **States:** IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - PSEL=0, PENABLE=0, cmd_ready=1.
  - On accept: latch addr, wdata, strb, prot and write into the APB output registers, then go to SETUP.
- **SETUP** (exactly 1 cycle): PSEL=1, PENABLE=0, cmd_ready=0; next state is ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1; the APB outputs hold stable.
  - PREADY=1 at the edge: capture rsp_rdata = PRDATA on reads (0 on writes), rsp_slverr = PSLVERR, rsp_timeout=0; go to RESP.
  - PREADY=0: increment the wait counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0: rsp_rdata=0, rsp_slverr=1, rsp_timeout=1; go to RESP.
  - PREADY=1 on the same edge the timeout would fire: normal completion wins.
  - The wait counter clears on entry to SETUP. Its width is enough to hold TIMEOUT_CYCLES.
- **RESP**
  - PSEL=0, PENABLE=0, rsp_valid=1; the response fields hold until the handshake.
  - cmd_ready = rsp_ready.
  - rsp_ready=1 with cmd_valid=1: accept the new command and go straight to SETUP (back-to-back).
  - rsp_ready=1 with cmd_valid=0: go to IDLE.
- **Output rules**
  - PSTRB is forced to 0 on reads and equals cmd_strb on writes.
  - PWDATA holds the latched value on reads; its value is don't-care to the slave.
  - PADDR, PWRITE, PPROT, PSTRB and PWDATA hold their last values while in IDLE/RESP.
  - All outputs are registered; no combinational path from any input to an APB output.
- **Reset**
  - Reset asserted at any time, including mid-ACCESS: all outputs go to 0 immediately and the state goes to IDLE.
  - The in-flight transfer is dropped with no response.
  - cmd_ready is 0 while reset is asserted and becomes 1 on the first rising edge after release.

## Timing
- Command accepted at edge N: SETUP during N→N+1, ACCESS from N+1.
- Zero wait states: PREADY sampled at edge N+2; rsp_valid=1 from N+2.
- Latency from accept to rsp_valid is 2+W cycles, where W is the number of wait cycles.
- Back-to-back throughput: one transfer per 3+W cycles (SETUP, ACCESS, RESP).
- Timeout response: rsp_valid asserts TIMEOUT_CYCLES+2 cycles after accept. PSEL drops on the same edge.
- rsp_valid remains high indefinitely under rsp_ready=0; no further APB activity occurs while it waits.
- PSEL is never asserted without a following PENABLE cycle. PENABLE never rises without a preceding SETUP cycle.

## Test plan
- Write 0x000 ← 0x12, then read 0x000 with a zero-wait slave → PSEL/PENABLE sequence 1/0 then 1/1; rsp_rdata=0x00000012, rsp_slverr=0; each transfer shows 2-cycle latency.
- Read 0x00C with the slave inserting 3 wait states and returning 0x0000002A → PENABLE high for 4 cycles, rsp_valid at accept+5, rsp_rdata=0x2A, PADDR stable throughout.
- Write 0x100 with the slave returning PSLVERR=1 → rsp_slverr=1, rsp_timeout=0, rsp_rdata=0. Then a read with PSTRB checked → PSTRB=0.
- TIMEOUT_CYCLES=4 and a slave that never asserts PREADY → abort after 4 ACCESS cycles: rsp_timeout=1, rsp_slverr=1, PSEL=0 at accept+6. A second case with PREADY rising in the 4th ACCESS cycle → normal completion.
- Four queued commands with rsp_ready held at 1 → transfers every 3 cycles with no IDLE gap. With rsp_ready=0 for 5 cycles → rsp_valid held, PSEL=0, cmd_ready=0.
- Assert rst low in the 2nd ACCESS cycle → all outputs 0 asynchronously, no rsp_valid. After release, a new read of 0x004 completes normally.
